// File: rtl/baud_tick_gen.sv
// Reloading baud divider with oversample sub-counter for the SPART TX/RX path.
// Optional phase realign input enabled by defining BAUD_TICK_RESYNC_EN.
module baud_tick_gen #(
  parameter int WIDTH      = 16,
  parameter int OVERSAMPLE = 16,
  localparam int SUB_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_buf,
`ifdef BAUD_TICK_RESYNC_EN
  input  logic             resync,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic [SUB_W-1:0] sub_count,
  output logic             tick,
  output logic             bit_tick
);

  localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(OVERSAMPLE / 2);

  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic             tick_q, tick_d;
  logic             bit_q, bit_d;
  logic             resync_w;

`ifdef BAUD_TICK_RESYNC_EN
  assign resync_w = resync;
`else
  assign resync_w = 1'b0;
`endif

  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    sub_d  = sub_q;
    tick_d = 1'b0;
    bit_d  = 1'b0;
    if (load) begin
      div_d = div_buf;
      cnt_d = div_buf;
      sub_d = '0;
    end else if (resync_w) begin
      // Realign so the next bit tick lands at mid-bit
      cnt_d = div_q;
      sub_d = SUB_HALF;
    end else if (en) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else begin
        cnt_d  = div_q;
        tick_d = 1'b1;
        if (sub_q == SUB_MAX) begin
          sub_d = '0;
          bit_d = 1'b1;
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      cnt_q  <= '0;
      sub_q  <= '0;
      tick_q <= 1'b0;
      bit_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      sub_q  <= sub_d;
      tick_q <= tick_d;
      bit_q  <= bit_d;
    end
  end

  assign count_out = cnt_q;
  assign sub_count = sub_q;
  assign tick      = tick_q;
  assign bit_tick  = bit_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: OVERSAMPLE=16 and OVERSAMPLE=1 instances.
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] div_buf;
  logic        en1, load1;
  logic [15:0] div1;
`ifdef BAUD_TICK_RESYNC_EN
  logic        resync;
`endif
  logic [15:0] cnt0, cnt1;
  logic [3:0]  sub0;
  logic [0:0]  sub1;
  logic        tick0, bit0, tick1, bit1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  baud_tick_gen #(.WIDTH(16), .OVERSAMPLE(16)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .div_buf  (div_buf),
`ifdef BAUD_TICK_RESYNC_EN
    .resync   (resync),
`endif
    .count_out(cnt0),
    .sub_count(sub0),
    .tick     (tick0),
    .bit_tick (bit0)
  );

  baud_tick_gen #(.WIDTH(16), .OVERSAMPLE(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .en       (en1),
    .load     (load1),
    .div_buf  (div1),
`ifdef BAUD_TICK_RESYNC_EN
    .resync   (1'b0),
`endif
    .count_out(cnt1),
    .sub_count(sub1),
    .tick     (tick1),
    .bit_tick (bit1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] cexp [8];
    logic        texp [8];
    cexp = '{16'd2, 16'd1, 16'd0, 16'd3, 16'd2, 16'd1, 16'd0, 16'd3};
    texp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; en = 1'b0; load = 1'b0; div_buf = 16'd0;
    en1 = 1'b0; load1 = 1'b0; div1 = 16'd0;
`ifdef BAUD_TICK_RESYNC_EN
    resync = 1'b0;
`endif
    cyc(); cyc();
    chk("rst_cnt", 32'(cnt0), 0);
    chk("rst_sub", 32'(sub0), 0);
    chk("rst_tick", 32'(tick0), 0);
    chk("rst_bit", 32'(bit0), 0);

    // after reset div_reg=0 gives a tick every enabled cycle
    rst = 1'b0; en = 1'b1;
    cyc();
    chk("div0_tick", 32'(tick0), 1);
    chk("div0_sub", 32'(sub0), 1);
    chk("div0_cnt", 32'(cnt0), 0);

    // basic divide by 4
    load = 1'b1; div_buf = 16'd3;
    cyc();
    load = 1'b0;
    chk("ld3_cnt", 32'(cnt0), 3);
    chk("ld3_sub", 32'(sub0), 0);
    chk("ld3_tick", 32'(tick0), 0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("div3_cnt", 32'(cnt0), 32'(cexp[i]));
      chk("div3_tick", 32'(tick0), 32'(texp[i]));
    end
    for (int i = 9; i <= 128; i++) begin
      cyc();
      chk("div3_ptick", 32'(tick0), 32'(i % 4 == 0));
      chk("div3_bit", 32'(bit0), 32'(i % 64 == 0));
    end

    // reset mid-count
    cyc();
    rst = 1'b1;
    cyc(); cyc();
    chk("mrst_cnt", 32'(cnt0), 0);
    chk("mrst_sub", 32'(sub0), 0);
    chk("mrst_tick", 32'(tick0), 0);
    chk("mrst_bit", 32'(bit0), 0);
    rst = 1'b0;

    // enable gap stretches the period
    load = 1'b1; div_buf = 16'd5; en = 1'b1;
    cyc();
    load = 1'b0;
    cyc(); cyc(); cyc();
    chk("gap_pre", 32'(cnt0), 2);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("gap_hold", 32'(cnt0), 2);
      chk("gap_tick", 32'(tick0), 0);
    end
    en = 1'b1;
    cyc();
    chk("gap_c7", 32'(cnt0), 1);
    chk("gap_t7", 32'(tick0), 0);
    cyc();
    chk("gap_c8", 32'(cnt0), 0);
    chk("gap_t8", 32'(tick0), 0);
    cyc();
    chk("gap_t9", 32'(tick0), 1);
    chk("gap_c9", 32'(cnt0), 5);

    // load during counting wins over decrement
    cyc(); cyc(); cyc(); cyc();
    chk("mld_pre", 32'(cnt0), 1);
    chk("mld_sub_pre", 32'(sub0), 1);
    load = 1'b1; div_buf = 16'd7;
    cyc();
    load = 1'b0;
    chk("mld_cnt", 32'(cnt0), 7);
    chk("mld_tick", 32'(tick0), 0);
    chk("mld_sub", 32'(sub0), 0);
    div_buf = 16'd2;
    cyc();
    chk("mld_dec", 32'(cnt0), 6);
    for (int i = 0; i < 7; i++) cyc();
    chk("nold_cnt", 32'(cnt0), 7);
    chk("nold_tick", 32'(tick0), 1);

`ifdef BAUD_TICK_RESYNC_EN
    load = 1'b1; div_buf = 16'd1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("rs_pre", 32'(sub0), 3);
    resync = 1'b1;
    cyc();
    resync = 1'b0;
    chk("rs_sub", 32'(sub0), 8);
    chk("rs_cnt", 32'(cnt0), 1);
    chk("rs_tick", 32'(tick0), 0);
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk("rs_bit", 32'(bit0), 32'(i == 16));
    end
`endif

    // OVERSAMPLE=1 with zero divisor
    load1 = 1'b1; div1 = 16'd0; en1 = 1'b1;
    cyc();
    load1 = 1'b0;
    chk("os1_ld_tick", 32'(tick1), 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("os1_tick", 32'(tick1), 1);
      chk("os1_bit", 32'(bit1), 1);
      chk("os1_cnt", 32'(cnt1), 0);
      chk("os1_sub", 32'(sub1), 0);
    end
    load1 = 1'b1; div1 = 16'd2;
    cyc();
    load1 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("os1d2_tick", 32'(tick1), 32'(i % 3 == 0));
      chk("os1d2_bit", 32'(bit1), 32'(i % 3 == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
